xtreme_search_mc: RTL and testbench
===================================

XTREME_SEARCH_MC -- requirements
Module: xtreme_search_mc

Interface
REQ-001 Parameter NB_PIXEL, default 19, width of one signed/unsigned sample per channel.
REQ-002 Parameter NB_COUNT, default 32, width of the frame-size and sample counter.
REQ-003 Parameter N_CH, default 2, number of parallel channels searched concurrently.
REQ-004 Parameter SIGNED, default 1, 1 = two's-complement compare, 0 = unsigned compare.
REQ-005 clock  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 i_start  input  1  frame start request; sampled only in IDLE.
REQ-008 i_valid  input  1  i_convValue holds a sample this cycle.
REQ-009 i_imageSize  input  NB_COUNT  number of samples per frame; latched on accepted start.
REQ-010 i_convValue  input  N_CH*NB_PIXEL  channel c in bits [c*NB_PIXEL +: NB_PIXEL].
REQ-011 o_maxValue  output  N_CH*NB_PIXEL  per-channel frame maximum, same packing.
REQ-012 o_minValue  output  N_CH*NB_PIXEL  per-channel frame minimum, same packing.
REQ-013 o_range  output  N_CH*(NB_PIXEL+1)  per-channel max minus min, unsigned, never overflows.
REQ-014 o_endSignal  output  1  one-cycle pulse: results updated.
REQ-015 o_busy  output  1  high in RUN state.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE -> RUN on i_start when latched size nonzero; IDLE -> DONE on i_start with i_imageSize = 0; RUN -> DONE on acceptance of sample number imageSize; DONE -> IDLE unconditionally after one cycle.
REQ-017 Sample accepted only when state = RUN and i_valid = 1; i_valid in IDLE/DONE ignored; i_start outside IDLE ignored.
REQ-018 First accepted sample of a frame loads running max and min of every channel; later samples replace max if strictly greater, min if strictly less.
REQ-019 Compare signedness per SIGNED, applied identically to all channels.
REQ-020 Sample counter increments per accepted sample, cleared on entering RUN; no wrap within a frame since terminal count ends the frame.
REQ-021 In DONE: o_maxValue, o_minValue, o_range registered from running values including the final sample; o_endSignal = 1 for exactly that cycle; latency last accepted sample -> o_endSignal = 1 cycle.
REQ-022 Zero-size frame: DONE reached with all result outputs 0 and o_endSignal pulsed.
REQ-023 Result outputs hold between frames until the next DONE; running registers never visible directly.
REQ-024 o_range computed in NB_PIXEL+1 bits with operands extended per SIGNED.
REQ-025 i_start asserted in the DONE cycle ignored; earliest new frame start is the following IDLE cycle.

Reset
REQ-026 reset forces IDLE, clears counter, running registers, and all outputs to 0, asynchronously, at any state including mid-frame.
REQ-027 A frame interrupted by reset produces no o_endSignal and no result update.

Structure
REQ-028 Package xtreme_pkg holds state encoding typedef and default parameter constants.
REQ-029 Sub-module xtreme_lane implements one channel's running max/min/range with a load/update/commit interface; top instantiates N_CH lanes via generate and owns FSM and counter.

Verification
REQ-030 N_CH=2, SIGNED=1, size 5, ch0 {3,-1,7,2,0}, ch1 {-4,-4,-4,-4,-4} -> max {7,-4}, min {-1,-4}, range {8,0}, endSignal one cycle after 5th sample.
REQ-031 SIGNED=0, size 3, ch0 {0x7FFFF,1,0} -> max 0x7FFFF, min 0, range 0x7FFFF.
REQ-032 Size 4 with gaps (i_valid low 3 cycles between samples) -> only valid samples counted, endSignal after 4th valid.
REQ-033 Start with size 0 -> endSignal next cycle, all results 0, o_busy never high.
REQ-034 Reset asserted after 2 of 10 samples, then new size-2 frame {5,6} -> no endSignal for aborted frame, results max 6, min 5.
REQ-035 Signed extremes -2^18 and 2^18-1 in one frame -> range 2^19-1 with no overflow.

Source files
------------

// File: rtl/xtreme_pkg.sv
// Shared state encoding and default parameter constants for the
// min/max/range search block.
package xtreme_pkg;

  localparam int NB_PIXEL_DEF = 19;
  localparam int NB_COUNT_DEF = 32;
  localparam int N_CH_DEF     = 2;
  localparam int SIGNED_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } xtremeState_t;

endpackage

// File: rtl/xtreme_lane.sv
// One channel of the search: running max/min plus committed result
// registers (max, min and max-min range).
module xtreme_lane #(
  parameter int NB_PIXEL = 19,
  parameter int SIGNED   = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NB_PIXEL-1:0] i_sample,
  input  logic                i_load,
  input  logic                i_update,
  input  logic                i_commit,
  input  logic                i_clear,
  output logic [NB_PIXEL-1:0] o_max,
  output logic [NB_PIXEL-1:0] o_min,
  output logic [NB_PIXEL:0]   o_range
);

  logic [NB_PIXEL-1:0] runMax;
  logic [NB_PIXEL-1:0] runMin;
  logic [NB_PIXEL-1:0] nextMax;
  logic [NB_PIXEL-1:0] nextMin;
  logic                gtMax;
  logic                ltMin;
  logic [NB_PIXEL:0]   extMax;
  logic [NB_PIXEL:0]   extMin;

  always_comb begin
    if (SIGNED != 0) begin
      gtMax = $signed(i_sample) > $signed(runMax);
      ltMin = $signed(i_sample) < $signed(runMin);
    end else begin
      gtMax = i_sample > runMax;
      ltMin = i_sample < runMin;
    end
  end

  // Commit uses the next values so the final sample is included in the
  // same edge that accepts it.
  always_comb begin
    nextMax = runMax;
    nextMin = runMin;
    if (i_load) begin
      nextMax = i_sample;
      nextMin = i_sample;
    end else if (i_update) begin
      if (gtMax) nextMax = i_sample;
      if (ltMin) nextMin = i_sample;
    end
  end

  always_comb begin
    extMax = {((SIGNED != 0) & nextMax[NB_PIXEL-1]), nextMax};
    extMin = {((SIGNED != 0) & nextMin[NB_PIXEL-1]), nextMin};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      runMax  <= '0;
      runMin  <= '0;
      o_max   <= '0;
      o_min   <= '0;
      o_range <= '0;
    end else begin
      runMax <= nextMax;
      runMin <= nextMin;
      if (i_clear) begin
        o_max   <= '0;
        o_min   <= '0;
        o_range <= '0;
      end else if (i_commit) begin
        o_max   <= nextMax;
        o_min   <= nextMin;
        o_range <= extMax - extMin;
      end
    end
  end

endmodule

// File: rtl/xtreme_search_mc.sv
// Multi-channel frame min/max/range search: FSM and sample counter here,
// per-channel tracking in xtreme_lane instances.
module xtreme_search_mc
  import xtreme_pkg::*;
#(
  parameter int NB_PIXEL = NB_PIXEL_DEF,
  parameter int NB_COUNT = NB_COUNT_DEF,
  parameter int N_CH     = N_CH_DEF,
  parameter int SIGNED   = SIGNED_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_start,
  input  logic                           i_valid,
  input  logic [NB_COUNT-1:0]            i_imageSize,
  input  logic [N_CH*NB_PIXEL-1:0]       i_convValue,
  output logic [N_CH*NB_PIXEL-1:0]       o_maxValue,
  output logic [N_CH*NB_PIXEL-1:0]       o_minValue,
  output logic [N_CH*(NB_PIXEL+1)-1:0]   o_range,
  output logic                           o_endSignal,
  output logic                           o_busy
);

  xtremeState_t        state;
  xtremeState_t        nextState;
  logic [NB_COUNT-1:0] count;
  logic [NB_COUNT-1:0] sizeReg;
  logic                accept;
  logic                firstSample;
  logic                lastSample;
  logic                zeroStart;

  always_comb begin
    accept      = (state == RUN) && i_valid;
    firstSample = accept && (count == '0);
    lastSample  = accept && ((count + NB_COUNT'(1)) == sizeReg);
    zeroStart   = (state == IDLE) && i_start && (i_imageSize == '0);
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (i_start) nextState = (i_imageSize == '0) ? DONE : RUN;
      RUN:  if (lastSample) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      sizeReg <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        count <= '0;
        if (i_start) sizeReg <= i_imageSize;
      end else if (accept) begin
        count <= count + NB_COUNT'(1);
      end
    end
  end

  always_comb begin
    o_endSignal = (state == DONE);
    o_busy      = (state == RUN);
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    xtreme_lane #(
      .NB_PIXEL (NB_PIXEL),
      .SIGNED   (SIGNED)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .i_sample (i_convValue[c*NB_PIXEL +: NB_PIXEL]),
      .i_load   (firstSample),
      .i_update (accept && !firstSample),
      .i_commit (lastSample),
      .i_clear  (zeroStart),
      .o_max    (o_maxValue[c*NB_PIXEL +: NB_PIXEL]),
      .o_min    (o_minValue[c*NB_PIXEL +: NB_PIXEL]),
      .o_range  (o_range[c*(NB_PIXEL+1) +: (NB_PIXEL+1)])
    );
  end

endmodule

// File: tb/tb_xtreme_search_mc.sv
// Bench for xtreme_search_mc: a signed and an unsigned instance share the
// stimulus and are checked against a behavioural min/max model.
module tb_xtreme_search_mc;

  localparam int NBP = 19;
  localparam int NCH = 2;
  localparam int NBC = 32;
  localparam int W   = NCH*NBP;
  localparam int RW  = NCH*(NBP+1);

  logic           clock = 1'b0;
  logic           reset;
  logic           i_start;
  logic           i_valid;
  logic [NBC-1:0] i_imageSize;
  logic [W-1:0]   i_convValue;
  logic [W-1:0]   maxS, minS, maxU, minU;
  logic [RW-1:0]  rngS, rngU;
  logic           endS, endU, busyS, busyU;

  xtreme_search_mc #(.NB_PIXEL(NBP), .NB_COUNT(NBC), .N_CH(NCH), .SIGNED(1)) dutS (
    .clock(clock), .reset(reset), .i_start(i_start), .i_valid(i_valid),
    .i_imageSize(i_imageSize), .i_convValue(i_convValue),
    .o_maxValue(maxS), .o_minValue(minS), .o_range(rngS),
    .o_endSignal(endS), .o_busy(busyS));

  xtreme_search_mc #(.NB_PIXEL(NBP), .NB_COUNT(NBC), .N_CH(NCH), .SIGNED(0)) dutU (
    .clock(clock), .reset(reset), .i_start(i_start), .i_valid(i_valid),
    .i_imageSize(i_imageSize), .i_convValue(i_convValue),
    .o_maxValue(maxU), .o_minValue(minU), .o_range(rngU),
    .o_endSignal(endU), .o_busy(busyU));

  always #5 clock = ~clock;

  int nChecks = 0;
  int nFail   = 0;

  logic [W-1:0]  frameData[$];
  logic [W-1:0]  expMaxS, expMinS, expMaxU, expMinU;
  logic [RW-1:0] expRngS, expRngU;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] pack2(input int a, input int b);
    return {b[NBP-1:0], a[NBP-1:0]};
  endfunction

  function automatic logic [W-1:0] randWord();
    return W'({$urandom, $urandom});
  endfunction

  // Reference: plain integer max/min over the frame, signed and unsigned views.
  task automatic computeExpected();
    expMaxS = '0; expMinS = '0; expMaxU = '0; expMinU = '0;
    expRngS = '0; expRngU = '0;
    for (int c = 0; c < NCH; c++) begin
      longint sMax, sMin, uMax, uMin, sv, uv, d;
      logic [NBP-1:0]        raw;
      logic signed [NBP-1:0] sr;
      sMax = 0; sMin = 0; uMax = 0; uMin = 0;
      for (int i = 0; i < frameData.size(); i++) begin
        raw = frameData[i][c*NBP +: NBP];
        sr  = raw;
        sv  = sr;
        uv  = longint'(raw);
        if (i == 0) begin
          sMax = sv; sMin = sv; uMax = uv; uMin = uv;
        end else begin
          if (sv > sMax) sMax = sv;
          if (sv < sMin) sMin = sv;
          if (uv > uMax) uMax = uv;
          if (uv < uMin) uMin = uv;
        end
      end
      expMaxS[c*NBP +: NBP] = sMax[NBP-1:0];
      expMinS[c*NBP +: NBP] = sMin[NBP-1:0];
      expMaxU[c*NBP +: NBP] = uMax[NBP-1:0];
      expMinU[c*NBP +: NBP] = uMin[NBP-1:0];
      d = sMax - sMin;
      expRngS[c*(NBP+1) +: (NBP+1)] = d[NBP:0];
      d = uMax - uMin;
      expRngU[c*(NBP+1) +: (NBP+1)] = d[NBP:0];
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".maxS"}, 64'(maxS), 64'(expMaxS));
    check({tag, ".minS"}, 64'(minS), 64'(expMinS));
    check({tag, ".rngS"}, 64'(rngS), 64'(expRngS));
    check({tag, ".maxU"}, 64'(maxU), 64'(expMaxU));
    check({tag, ".minU"}, 64'(minU), 64'(expMinU));
    check({tag, ".rngU"}, 64'(rngU), 64'(expRngU));
  endtask

  // Runs one frame from IDLE using frameData; gapMode < 0 gives random gaps.
  task automatic runFrame(input string tag, input int gapMode);
    int size;
    int gaps;
    size = frameData.size();
    i_start = 1'b1;
    i_imageSize = NBC'(size);
    step();
    i_start = 1'b0;
    i_imageSize = $urandom;
    if (size == 0) begin
      check({tag, ".zeroEnd"}, 64'({endS, endU}), 64'(2'b11));
      check({tag, ".zeroBusy"}, 64'({busyS, busyU}), 64'(2'b00));
    end else begin
      check({tag, ".busy"}, 64'({busyS, busyU}), 64'(2'b11));
      for (int i = 0; i < size; i++) begin
        gaps = (gapMode < 0) ? int'($urandom_range(0, 2)) : gapMode;
        repeat (gaps) begin
          i_valid = 1'b0;
          i_convValue = randWord();
          step();
          check({tag, ".gapEnd"}, 64'({endS, endU}), 64'(2'b00));
        end
        i_valid = 1'b1;
        i_convValue = frameData[i];
        step();
        i_valid = 1'b0;
        if (i < size - 1)
          check({tag, ".midEnd"}, 64'({endS, endU, busyS}), 64'(3'b001));
        else
          check({tag, ".lastEnd"}, 64'({endS, endU, busyS}), 64'(3'b110));
      end
    end
    computeExpected();
    checkAll(tag);
    // Valid and start during DONE must both be ignored.
    i_valid = 1'b1;
    i_convValue = randWord();
    i_start = 1'b1;
    i_imageSize = 3;
    step();
    i_valid = 1'b0;
    i_start = 1'b0;
    check({tag, ".afterDone"}, 64'({endS, endU, busyS, busyU}), 64'(4'b0000));
    checkAll({tag, ".hold"});
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_imageSize = '0;
    i_convValue = '0;
    step();
    step();
    frameData = {};
    computeExpected();
    check("reset.ctl", 64'({endS, endU, busyS, busyU}), 64'(4'b0000));
    checkAll("reset");
    reset = 1'b0;
    step();

    frameData = {pack2(3, -4), pack2(-1, -4), pack2(7, -4), pack2(2, -4), pack2(0, -4)};
    runFrame("basic", 0);
    check("basic.maxConst", 64'(maxS), 64'(pack2(7, -4)));
    check("basic.minConst", 64'(minS), 64'(pack2(-1, -4)));
    check("basic.rngConst", 64'(rngS), 64'({20'd0, 20'd8}));

    frameData = {pack2('h7FFFF, 5), pack2(1, 5), pack2(0, 5)};
    runFrame("unsig", 0);
    check("unsig.maxConst", 64'(maxU[NBP-1:0]), 64'h7FFFF);
    check("unsig.minConst", 64'(minU[NBP-1:0]), 64'h0);
    check("unsig.rngConst", 64'(rngU[NBP:0]), 64'h7FFFF);

    frameData = {};
    repeat (4) frameData.push_back(randWord());
    runFrame("gaps", 3);

    frameData = {};
    runFrame("zero", 0);
    check("zero.maxConst", 64'(maxS), 64'h0);

    // Abort a size-10 frame with reset after two samples.
    i_start = 1'b1;
    i_imageSize = 10;
    step();
    i_start = 1'b0;
    repeat (2) begin
      i_valid = 1'b1;
      i_convValue = randWord();
      step();
    end
    i_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    frameData = {};
    computeExpected();
    check("abort.ctl", 64'({endS, endU, busyS, busyU}), 64'(4'b0000));
    checkAll("abort");
    step();
    reset = 1'b0;
    repeat (2) begin
      step();
      check("abort.noEnd", 64'({endS, endU, busyS}), 64'(3'b000));
    end
    frameData = {pack2(5, 5), pack2(6, 6)};
    runFrame("postAbort", 1);
    check("postAbort.maxConst", 64'(maxS), 64'(pack2(6, 6)));
    check("postAbort.minConst", 64'(minS), 64'(pack2(5, 5)));

    frameData = {pack2(-262144, 0), pack2(262143, 1)};
    runFrame("extreme", 0);
    check("extreme.rngConst", 64'(rngS[NBP:0]), 64'h7FFFF);

    // Valid pulses while idle must not disturb the next frame.
    repeat (3) begin
      i_valid = 1'b1;
      i_convValue = randWord();
      step();
    end
    i_valid = 1'b0;

    frameData = {randWord()};
    runFrame("single", 0);

    for (int f = 0; f < 20; f++) begin
      int sz;
      sz = int'($urandom_range(1, 12));
      frameData = {};
      repeat (sz) frameData.push_back(randWord());
      runFrame("rand", -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
